// File: rtl/kf8237_bus_control_param.sv
// rtl/kf8237_bus_control_param.sv - KF8237 CPU bus decoder and byte-pointer owner for CHANNELS channels.
// Optional input synchroniser enabled by defining KF8237_BUS_INPUT_SYNC_EN.
module kf8237_bus_control_param #(
  parameter int CHANNELS      = 4,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     chip_select_n,
  input  logic                     io_read_n_in,
  input  logic                     io_write_n_in,
  input  logic [ADDRESS_WIDTH-1:0] address_in,
  input  logic [7:0]               data_bus_in,
  input  logic                     lock_bus_control,
  output logic [7:0]               internal_data_bus,
  output logic                     byte_pointer,
  output logic                     write_command_register,
  output logic                     write_mode_register,
  output logic                     write_request_register,
  output logic                     set_or_reset_mask_register,
  output logic                     write_mask_register,
  output logic                     clear_byte_pointer,
  output logic                     set_byte_pointer,
  output logic                     master_clear,
  output logic                     clear_mask_register,
  output logic [CHANNELS-1:0]      write_base_and_current_address,
  output logic [CHANNELS-1:0]      write_base_and_current_word_count,
  output logic [CHANNELS-1:0]      read_current_address,
  output logic [CHANNELS-1:0]      read_current_word_count,
  output logic                     read_temporary_register,
  output logic                     read_status_register
);

  localparam int AW1 = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH:0] CHAN_SPAN = AW1'(2 * CHANNELS);

  logic                     cs_n;
  logic                     rd_n;
  logic                     wr_n;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [7:0]               data;

`ifdef KF8237_BUS_INPUT_SYNC_EN
  logic [1:0]               cs_sync;
  logic [1:0]               rd_sync;
  logic [1:0]               wr_sync;
  logic [ADDRESS_WIDTH-1:0] addr_d1, addr_d2;
  logic [7:0]               data_d1, data_d2;

  always_ff @(posedge clock) begin
    if (reset) begin
      cs_sync <= 2'b11;
      rd_sync <= 2'b11;
      wr_sync <= 2'b11;
      addr_d1 <= '0;
      addr_d2 <= '0;
      data_d1 <= 8'h00;
      data_d2 <= 8'h00;
    end else begin
      cs_sync <= {cs_sync[0], chip_select_n};
      rd_sync <= {rd_sync[0], io_read_n_in};
      wr_sync <= {wr_sync[0], io_write_n_in};
      addr_d1 <= address_in;
      addr_d2 <= addr_d1;
      data_d1 <= data_bus_in;
      data_d2 <= data_d1;
    end
  end

  assign cs_n = cs_sync[1];
  assign rd_n = rd_sync[1];
  assign wr_n = wr_sync[1];
  assign addr = addr_d2;
  assign data = data_d2;
`else
  assign cs_n = chip_select_n;
  assign rd_n = io_read_n_in;
  assign wr_n = io_write_n_in;
  assign addr = address_in;
  assign data = data_bus_in;
`endif

  logic [ADDRESS_WIDTH-1:0] stable_address;
  logic                     prev_write_n;
  logic                     prev_read_n;

  // Deselect forces the edge detectors idle, so an aborted access never strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      internal_data_bus <= 8'h00;
      stable_address    <= '0;
      prev_write_n      <= 1'b1;
      prev_read_n       <= 1'b1;
    end else begin
      if (!wr_n && !cs_n)
        internal_data_bus <= data;
      stable_address <= addr;
      prev_write_n   <= cs_n ? 1'b1 : wr_n;
      prev_read_n    <= cs_n ? 1'b1 : rd_n;
    end
  end

  logic write_end;
  logic read_end;
  logic read_flag;

  assign write_end = ~prev_write_n & wr_n & ~lock_bus_control;
  assign read_end  = ~prev_read_n & rd_n & ~lock_bus_control;
  assign read_flag = ~rd_n & ~cs_n & ~lock_bus_control;

  // Control registers alias on the low three bits whenever the top address bit is set.
  logic                stable_ctrl;
  logic                stable_chan;
  logic [2:0]          stable_idx;
  logic                addr_ctrl;
  logic                addr_chan;
  logic [2:0]          addr_idx;
  logic [7:0]          write_ctrl;
  logic [CHANNELS-1:0] write_chan_sel;
  logic [CHANNELS-1:0] read_chan_sel;

  assign stable_ctrl = stable_address[ADDRESS_WIDTH-1];
  assign stable_chan = ~stable_ctrl && ({1'b0, stable_address} < CHAN_SPAN);
  assign stable_idx  = stable_address[2:0];
  assign addr_ctrl   = addr[ADDRESS_WIDTH-1];
  assign addr_chan   = ~addr_ctrl && ({1'b0, addr} < CHAN_SPAN);
  assign addr_idx    = addr[2:0];

  assign write_ctrl     = (write_end && stable_ctrl) ? (8'd1 << stable_idx) : 8'd0;
  assign write_chan_sel = (write_end && stable_chan)
                          ? (CHANNELS'(1) << stable_address[ADDRESS_WIDTH-1:1]) : '0;
  assign read_chan_sel  = (read_flag && addr_chan)
                          ? (CHANNELS'(1) << addr[ADDRESS_WIDTH-1:1]) : '0;

  assign write_command_register     = write_ctrl[0];
  assign write_request_register     = write_ctrl[1];
  assign set_or_reset_mask_register = write_ctrl[2];
  assign write_mode_register        = write_ctrl[3];
  assign clear_byte_pointer         = write_ctrl[4];
  assign master_clear               = write_ctrl[5];
  assign clear_mask_register        = write_ctrl[6];
  assign write_mask_register        = write_ctrl[7];

  assign write_base_and_current_address    = stable_address[0] ? '0 : write_chan_sel;
  assign write_base_and_current_word_count = stable_address[0] ? write_chan_sel : '0;
  assign read_current_address              = addr[0] ? '0 : read_chan_sel;
  assign read_current_word_count           = addr[0] ? read_chan_sel : '0;

  assign read_status_register    = read_flag && addr_ctrl && (addr_idx == 3'd0);
  assign set_byte_pointer        = read_flag && addr_ctrl && (addr_idx == 3'd4);
  assign read_temporary_register = read_flag && addr_ctrl && (addr_idx == 3'd5);

  logic byte_pointer_set;
  assign byte_pointer_set = read_end && stable_ctrl && (stable_idx == 3'd4);

  // Consumers see the pre-toggle value during the strobe cycle.
  always_ff @(posedge clock) begin
    if (reset)
      byte_pointer <= 1'b0;
    else if (master_clear || clear_byte_pointer)
      byte_pointer <= 1'b0;
    else if (byte_pointer_set)
      byte_pointer <= 1'b1;
    else if ((write_end || read_end) && stable_chan)
      byte_pointer <= ~byte_pointer;
  end

endmodule

// File: tb/tb_kf8237_bus_control_param.sv
// tb/tb_kf8237_bus_control_param.sv - self-checking bench for kf8237_bus_control_param (default and 8-channel builds).
module tb_kf8237_bus_control_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       cs_n, cs_n2, rd_n, wr_n, lock;
  logic [3:0] address;
  logic [4:0] address2;
  logic [7:0] data;

  logic [7:0] idb;
  logic       bp;
  logic       wcmd, wmode, wreq, wsrm, wmask, cbp, sbp, mclr, cmask, rtemp, rstat;
  logic [3:0] wa, wc, ra, rc;

  logic [7:0] idb2;
  logic       bp2;
  logic       wcmd2, wmode2, wreq2, wsrm2, wmask2, cbp2, sbp2, mclr2, cmask2, rtemp2, rstat2;
  logic [7:0] wa2, wc2, ra2, rc2;

  int   tests = 0;
  int   fails = 0;
  logic model_bp = 1'b0;

  always #5 clock = ~clock;

  kf8237_bus_control_param #(.CHANNELS(4), .ADDRESS_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .chip_select_n(cs_n), .io_read_n_in(rd_n),
    .io_write_n_in(wr_n), .address_in(address), .data_bus_in(data),
    .lock_bus_control(lock), .internal_data_bus(idb), .byte_pointer(bp),
    .write_command_register(wcmd), .write_mode_register(wmode),
    .write_request_register(wreq), .set_or_reset_mask_register(wsrm),
    .write_mask_register(wmask), .clear_byte_pointer(cbp), .set_byte_pointer(sbp),
    .master_clear(mclr), .clear_mask_register(cmask),
    .write_base_and_current_address(wa), .write_base_and_current_word_count(wc),
    .read_current_address(ra), .read_current_word_count(rc),
    .read_temporary_register(rtemp), .read_status_register(rstat)
  );

  kf8237_bus_control_param #(.CHANNELS(8), .ADDRESS_WIDTH(5)) dut8 (
    .clock(clock), .reset(reset), .chip_select_n(cs_n2), .io_read_n_in(rd_n),
    .io_write_n_in(wr_n), .address_in(address2), .data_bus_in(data),
    .lock_bus_control(lock), .internal_data_bus(idb2), .byte_pointer(bp2),
    .write_command_register(wcmd2), .write_mode_register(wmode2),
    .write_request_register(wreq2), .set_or_reset_mask_register(wsrm2),
    .write_mask_register(wmask2), .clear_byte_pointer(cbp2), .set_byte_pointer(sbp2),
    .master_clear(mclr2), .clear_mask_register(cmask2),
    .write_base_and_current_address(wa2), .write_base_and_current_word_count(wc2),
    .read_current_address(ra2), .read_current_word_count(rc2),
    .read_temporary_register(rtemp2), .read_status_register(rstat2)
  );

  // Write strobes: bits 7..0 are control offsets C+7..C+0, then count[3:0], then address[3:0].
  logic [15:0] wr_obs;
  logic [10:0] rd_obs;
  assign wr_obs = {wa, wc, wmask, cmask, mclr, cbp, wmode, wsrm, wreq, wcmd};
  assign rd_obs = {ra, rc, rtemp, sbp, rstat};

  function automatic logic [15:0] exp_wr(input int off);
    logic [15:0] v = 16'h0;
    if (off < 8) begin
      if (off % 2 == 1) v[8 + off / 2] = 1'b1;
      else              v[12 + off / 2] = 1'b1;
    end else begin
      v[off - 8] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [10:0] exp_rd(input int off);
    logic [10:0] v = 11'h0;
    if (off < 8) begin
      if (off % 2 == 1) v[3 + off / 2] = 1'b1;
      else              v[7 + off / 2] = 1'b1;
    end else begin
      case (off - 8)
        0:       v[0] = 1'b1;
        4:       v[1] = 1'b1;
        5:       v[2] = 1'b1;
        default: v = 11'h0;
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input int off, input logic [7:0] d, input logic lk);
    logic [15:0] e;
    e = lk ? 16'h0 : exp_wr(off);
    @(posedge clock); #1;
    address = off[3:0]; data = d; cs_n = 1'b0; wr_n = 1'b0; lock = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clock);
    #1;
    check("wr_hold_quiet", 32'(wr_obs), 32'h0);
    wr_n = 1'b1; lock = lk; #1;
    check("wr_strobe", 32'(wr_obs), 32'(e));
    check("wr_bp_pre", 32'(bp), 32'(model_bp));
    if (!lk) begin
      if (off == 12 || off == 13) model_bp = 1'b0;
      else if (off < 8)           model_bp = ~model_bp;
    end
    @(posedge clock); #1;
    cs_n = 1'b1; lock = 1'b0;
    check("wr_one_cycle", 32'(wr_obs), 32'h0);
    check("wr_bp_post", 32'(bp), 32'(model_bp));
    check("wr_idb", 32'(idb), 32'(d));
  endtask

  task automatic do_read(input int off, input logic lk);
    logic [10:0] e;
    e = exp_rd(off);
    @(posedge clock); #1;
    address = off[3:0]; cs_n = 1'b0; rd_n = 1'b0; lock = 1'b0; #1;
    check("rd_level", 32'(rd_obs), 32'(e));
    check("rd_no_wr", 32'(wr_obs), 32'h0);
    @(posedge clock); #1;
    check("rd_level_hold", 32'(rd_obs), 32'(e));
    rd_n = 1'b1; lock = lk; #1;
    check("rd_release", 32'(rd_obs), 32'h0);
    check("rd_bp_pre", 32'(bp), 32'(model_bp));
    if (!lk) begin
      if (off == 12)     model_bp = 1'b1;
      else if (off < 8)  model_bp = ~model_bp;
    end
    @(posedge clock); #1;
    cs_n = 1'b1; lock = 1'b0;
    check("rd_bp_post", 32'(bp), 32'(model_bp));
  endtask

  task automatic do_write8(input int off, input logic [7:0] e_wc, input logic e_cmd);
    @(posedge clock); #1;
    address2 = off[4:0]; cs_n2 = 1'b0; wr_n = 1'b0; data = 8'($urandom);
    @(posedge clock); #1;
    wr_n = 1'b1; #1;
    check("ch8_word_count", 32'(wc2), 32'(e_wc));
    check("ch8_command", 32'(wcmd2), 32'(e_cmd));
    @(posedge clock); #1;
    cs_n2 = 1'b1;
    check("ch8_one_cycle", 32'(wc2), 32'h0);
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; cs_n2 = 1'b1; rd_n = 1'b1; wr_n = 1'b1; lock = 1'b0;
    address = 4'h0; address2 = 5'h0; data = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("reset_wr_strobes", 32'(wr_obs), 32'h0);
    check("reset_rd_enables", 32'(rd_obs), 32'h0);
    check("reset_bp", 32'(bp), 32'h0);
    check("reset_idb", 32'(idb), 32'h0);

    do_write(2, 8'h5A, 1'b0);
    do_write(2, 8'h33, 1'b0);
    do_write(12, 8'h00, 1'b0);
    do_read(12, 1'b0);
    do_write(3, 8'hA7, 1'b1);

    // Deselect while write_n is still low: access is abandoned.
    @(posedge clock); #1;
    address = 4'd2; data = 8'hC3; cs_n = 1'b0; wr_n = 1'b0;
    @(posedge clock); #1;
    cs_n = 1'b1;
    @(posedge clock); #1;
    wr_n = 1'b1; #1;
    check("deselect_no_strobe", 32'(wr_obs), 32'h0);
    @(posedge clock); #1;
    check("deselect_bp", 32'(bp), 32'(model_bp));
    do_write(2, 8'h11, 1'b0);

    // Reset while a C+4 read is in flight: the read end must not set the pointer.
    @(posedge clock); #1;
    address = 4'd12; cs_n = 1'b0; rd_n = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; rd_n = 1'b1; model_bp = 1'b0; #1;
    check("rst_read_enables", 32'(rd_obs), 32'h0);
    @(posedge clock); #1;
    cs_n = 1'b1;
    check("rst_read_bp", 32'(bp), 32'h0);
    do_read(12, 1'b0);

    for (int i = 0; i < 48; i++) begin
      int   off;
      logic lk;
      off = int'($urandom_range(0, 15));
      lk  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) do_write(off, 8'($urandom), lk);
      else                           do_read(off, lk);
    end

    do_write8(15, 8'h80, 1'b0);
    do_write8(24, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
